// File: rtl/q_lwpipe_reserve_pkg.sv
// Shared constants and helpers for the pipelined stream link with a reserve queue.
package q_lwpipe_reserve_pkg;

  localparam int OCC_W = 9;

  // Tokens that can still be in flight after the queue raises back-pressure
  function automatic int reserve_of(input int lpipe, input int wpipe);
    return lpipe + 2 * wpipe;
  endfunction

endpackage

// File: rtl/q_lwpipe_reserve_if.sv
// Valid/back-pressure stream bundle: master drives d/v, slave drives b.
interface q_lwpipe_reserve_if #(
  parameter int width = 16
) ();
  logic [width-1:0] d;
  logic             v;
  logic             b;

  modport master (output d, output v, input b);
  modport slave  (input d, input v, output b);
endinterface

// File: rtl/q_lwpipe_reserve_core.sv
// SRL queue holding depth + reserve entries; back-pressure flags at depth, overflow drops and sticks.
module q_srl_reserve_core
  import q_lwpipe_reserve_pkg::*;
#(
  parameter int depth   = 16,
  parameter int width   = 16,
  parameter int reserve = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [width-1:0] push_d,
  input  logic             push_v,
  input  logic             pop_b,
  output logic [width-1:0] o_d,
  output logic             o_v,
  output logic             qb,
  output logic [OCC_W-1:0] occ,
  output logic             ovf
);

  localparam int CAP = depth + reserve;
  localparam int AW  = $clog2(CAP);

  logic [width-1:0] mem_q [CAP];
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             ovf_q, ovf_d;
  logic             pop, full, shift;
  logic [AW-1:0]    head_idx;

  always_comb begin
    pop   = (occ_q != '0) && !pop_b;
    full  = (occ_q == OCC_W'(CAP));
    shift = push_v && (!full || pop);
    occ_d = occ_q;
    ovf_d = ovf_q;
    if (shift && !pop) begin
      occ_d = occ_q + OCC_W'(1);
    end else if (!shift && pop) begin
      occ_d = occ_q - OCC_W'(1);
    end
    if (push_v && full && !pop) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      occ_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      occ_q <= occ_d;
      ovf_q <= ovf_d;
    end
  end

  // Entries shift toward higher indices; the oldest sits at occ-1
  always_ff @(posedge clock) begin
    if (shift) begin
      mem_q[0] <= push_d;
      for (int k = 1; k < CAP; k++) begin
        mem_q[k] <= mem_q[k-1];
      end
    end
  end

  assign head_idx = AW'(occ_q - OCC_W'(1));
  assign o_v      = (occ_q != '0);
  assign o_d      = o_v ? mem_q[head_idx] : '0;
  assign qb       = (occ_q >= OCC_W'(depth));
  assign occ      = occ_q;
  assign ovf      = ovf_q;

endmodule

// File: rtl/q_lwpipe_reserve.sv
// Pipelined stream link: logic pipe, interconnect pipe both ways, then a reserve queue.
module q_lwpipe_reserve
  import q_lwpipe_reserve_pkg::*;
#(
  parameter int depth = 16,
  parameter int width = 16,
  parameter int lpipe = 0,
  parameter int wpipe = 0
) (
  input  logic             clock,
  input  logic             reset,
  q_lwpipe_reserve_if.slave  in_if,
  q_lwpipe_reserve_if.master out_if,
  output logic [OCC_W-1:0] occ,
  output logic             ovf
);

  localparam int R = reserve_of(lpipe, wpipe);

  if (depth < 2 || depth > 256) begin : g_bad_depth
    $error("q_lwpipe_reserve: depth must be in 2..256");
  end
  if (R > 255) begin : g_bad_reserve
    $error("q_lwpipe_reserve: lpipe + 2*wpipe must not exceed 255");
  end

  logic             l_v, w_v, qb;
  logic [width-1:0] l_d, w_d;

  // Logic pipe: forward only, raw input valid so protocol violations reach the queue
  if (lpipe > 0) begin : g_lpipe
    logic             lv_q [lpipe];
    logic [width-1:0] ld_q [lpipe];
    always_ff @(posedge clock) begin
      if (reset) begin
        for (int k = 0; k < lpipe; k++) begin
          lv_q[k] <= 1'b0;
          ld_q[k] <= '0;
        end
      end else begin
        lv_q[0] <= in_if.v;
        ld_q[0] <= in_if.d;
        for (int k = 1; k < lpipe; k++) begin
          lv_q[k] <= lv_q[k-1];
          ld_q[k] <= ld_q[k-1];
        end
      end
    end
    assign l_v = lv_q[lpipe-1];
    assign l_d = ld_q[lpipe-1];
  end else begin : g_lbyp
    assign l_v = in_if.v;
    assign l_d = in_if.d;
  end

  if (wpipe > 0) begin : g_wpipe
    logic             wv_q [wpipe];
    logic [width-1:0] wd_q [wpipe];
    logic             wb_q [wpipe];
    always_ff @(posedge clock) begin
      if (reset) begin
        for (int k = 0; k < wpipe; k++) begin
          wv_q[k] <= 1'b0;
          wd_q[k] <= '0;
          wb_q[k] <= 1'b1;
        end
      end else begin
        wv_q[0] <= l_v;
        wd_q[0] <= l_d;
        wb_q[0] <= qb;
        for (int k = 1; k < wpipe; k++) begin
          wv_q[k] <= wv_q[k-1];
          wd_q[k] <= wd_q[k-1];
          wb_q[k] <= wb_q[k-1];
        end
      end
    end
    assign w_v     = wv_q[wpipe-1];
    assign w_d     = wd_q[wpipe-1];
    assign in_if.b = wb_q[wpipe-1];
  end else begin : g_wbyp
    assign w_v     = l_v;
    assign w_d     = l_d;
    assign in_if.b = qb;
  end

  q_srl_reserve_core #(
    .depth  (depth),
    .width  (width),
    .reserve(R)
  ) u_core (
    .clock (clock),
    .reset (reset),
    .push_d(w_d),
    .push_v(w_v),
    .pop_b (out_if.b),
    .o_d   (out_if.d),
    .o_v   (out_if.v),
    .qb    (qb),
    .occ   (occ),
    .ovf   (ovf)
  );

endmodule
